// File: rtl/bcd_divider_seq_pkg.sv
// Shared types and helpers for the BCD arithmetic blocks: nibble type,
// largest BCD digit, divider FSM states and a digit-validity check.
package bcd_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic bcd_digit_valid(input nibble_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_divider_seq_if.sv
// Request/result bundle of the sequential BCD divider; DIGITS must match the
// divider instance it is connected to.
interface bcd_divider_seq_if #(parameter int DIGITS = 4);

    logic                  start;
    logic [4*DIGITS-1:0]   dividend;
    logic [4*DIGITS-1:0]   divisor;
    logic [4*DIGITS-1:0]   quotient;
    logic [4*DIGITS-1:0]   remainder;
    logic                  busy;
    logic                  done;
    logic                  div_zero;
    logic                  bcd_err;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero, bcd_err
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero, bcd_err
    );

endinterface

// File: rtl/bcd_divider_seq_sub.sv
// Ripple-borrow packed-BCD subtractor a - b. The borrow-out doubles as the
// a < b comparison used by the divider.
import bcd_pkg::*;

module bcd_sub_ndigit #(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] diff,
    output logic                borrow
);

    logic [DIGITS:0] bc;

    assign bc[0] = 1'b0;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [4:0] raw;
        nibble_t    low;

        // 5-bit difference; bit 4 set means this digit went negative
        assign raw = {1'b0, a[gi*4 +: 4]} - {1'b0, b[gi*4 +: 4]} - {4'b0000, bc[gi]};
        assign low = raw[3:0];
        assign diff[gi*4 +: 4] = raw[4] ? nibble_t'(low + 4'd10) : low;
        assign bc[gi+1]        = raw[4];
    end

    assign borrow = bc[DIGITS];

endmodule

// File: rtl/bcd_divider_seq.sv
// Digit-serial restoring BCD divider with divide-by-zero detection and a
// busy/done handshake. Define BCD_DIV_DIGIT_CHECK_EN to reject non-BCD operands.
import bcd_pkg::*;

module bcd_divider_seq #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    bcd_divider_seq_if.slave bus
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = 4 * (DIGITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state_reg, state_next;
    logic [W-1:0]    dividend_reg, dividend_next;
    logic [W-1:0]    divisor_reg, divisor_next;
    logic [PW-1:0]   pr_reg, pr_next;
    logic [W-1:0]    qwork_reg, qwork_next;
    nibble_t         qd_reg, qd_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            zero_reg, zero_next;
    logic [W-1:0]    quotient_reg, quotient_next;
    logic [W-1:0]    remainder_reg, remainder_next;
    logic            div_zero_reg, div_zero_next;
    logic            bcd_err_reg, bcd_err_next;
    logic            done_reg, done_next;

    logic [PW-1:0]   sub_diff;
    logic            sub_borrow;
    logic [W-1:0]    qword;

`ifdef BCD_DIV_DIGIT_CHECK_EN
    logic            bad_reg, bad_next;
    logic [DIGITS-1:0] digit_ok;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
        assign digit_ok[gi] = bcd_digit_valid(bus.dividend[gi*4 +: 4]) &
                              bcd_digit_valid(bus.divisor[gi*4 +: 4]);
    end
`endif

    bcd_sub_ndigit #(.DIGITS(DIGITS + 1)) u_sub (
        .a      (pr_reg),
        .b      ({4'h0, divisor_reg}),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            pr_reg        <= '0;
            qwork_reg     <= '0;
            qd_reg        <= '0;
            idx_reg       <= '0;
            zero_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
            bcd_err_reg   <= 1'b0;
            done_reg      <= 1'b0;
`ifdef BCD_DIV_DIGIT_CHECK_EN
            bad_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
            pr_reg        <= pr_next;
            qwork_reg     <= qwork_next;
            qd_reg        <= qd_next;
            idx_reg       <= idx_next;
            zero_reg      <= zero_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            div_zero_reg  <= div_zero_next;
            bcd_err_reg   <= bcd_err_next;
            done_reg      <= done_next;
`ifdef BCD_DIV_DIGIT_CHECK_EN
            bad_reg       <= bad_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        dividend_next  = dividend_reg;
        divisor_next   = divisor_reg;
        pr_next        = pr_reg;
        qwork_next     = qwork_reg;
        qd_next        = qd_reg;
        idx_next       = idx_reg;
        zero_next      = zero_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        div_zero_next  = div_zero_reg;
        bcd_err_next   = bcd_err_reg;
        done_next      = 1'b0;
        qword          = qwork_reg;
`ifdef BCD_DIV_DIGIT_CHECK_EN
        bad_next       = bad_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    dividend_next = bus.dividend;
                    divisor_next  = bus.divisor;
                    pr_next       = '0;
                    qwork_next    = '0;
                    qd_next       = '0;
                    idx_next      = IW'(DIGITS - 1);
                    zero_next     = (bus.divisor == '0);
`ifdef BCD_DIV_DIGIT_CHECK_EN
                    bad_next      = ~(&digit_ok);
`endif
                    state_next    = SHIFT;
                end
            end

            SHIFT: begin
                // Early exits are decided on the captured operands so the
                // result registers load exactly as they do for a normal finish.
`ifdef BCD_DIV_DIGIT_CHECK_EN
                if (bad_reg) begin
                    quotient_next  = '0;
                    remainder_next = '0;
                    div_zero_next  = 1'b0;
                    bcd_err_next   = 1'b1;
                    done_next      = 1'b1;
                    state_next     = DONE;
                end else
`endif
                if (zero_reg) begin
                    quotient_next  = {DIGITS{BCD_MAX}};
                    remainder_next = dividend_reg;
                    div_zero_next  = 1'b1;
                    bcd_err_next   = 1'b0;
                    done_next      = 1'b1;
                    state_next     = DONE;
                end else begin
                    pr_next    = {pr_reg[W-1:0], dividend_reg[idx_reg*4 +: 4]};
                    qd_next    = '0;
                    state_next = SUB;
                end
            end

            SUB: begin
                // qd saturating at 9 bounds the loop even for non-BCD operands
                if (!sub_borrow && (qd_reg != BCD_MAX)) begin
                    pr_next = sub_diff;
                    qd_next = qd_reg + 4'd1;
                end else begin
                    qword[idx_reg*4 +: 4] = qd_reg;
                    qwork_next = qword;
                    if (idx_reg == '0) begin
                        quotient_next  = qword;
                        remainder_next = pr_reg[W-1:0];
                        div_zero_next  = 1'b0;
                        bcd_err_next   = 1'b0;
                        done_next      = 1'b1;
                        state_next     = DONE;
                    end else begin
                        idx_next   = idx_reg - IW'(1);
                        state_next = SHIFT;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.div_zero  = div_zero_reg;
`ifdef BCD_DIV_DIGIT_CHECK_EN
    assign bus.bcd_err   = bcd_err_reg;
`else
    assign bus.bcd_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_divider_seq.sv
// Scoreboard bench for bcd_divider_seq: the driver queues expected results,
// the monitor pops and compares them whenever done is seen.
module tb_bcd_divider_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        be;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];

    bcd_divider_seq_if #(.DIGITS(4)) bus();

    bcd_divider_seq #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: one comparison set per observed done pulse
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient",  32'(bus.quotient),  32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_zero",  32'(bus.div_zero),  32'(e.dz));
                chk("bcd_err",   32'(bus.bcd_err),   32'(e.be));
                chk("latency",   32'(cyc - e.start_cyc), 32'(e.lat));
                $display("result q=%h r=%h dz=%b be=%b after %0d edges", bus.quotient,
                         bus.remainder, bus.div_zero, bus.bcd_err, cyc - e.start_cyc);
            end
        end
    end

    task automatic run(input logic [15:0] dvd, input logic [15:0] dvs,
                       input logic [15:0] q, input logic [15:0] r,
                       input logic dz, input logic be, input int lat, input int glitch);
        exp_t e;
        int   busy_low;
        bit   got;
        busy_low = 0;
        got = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        e.q = q; e.r = r; e.dz = dz; e.be = be; e.lat = lat; e.start_cyc = cyc;
        exp_q.push_back(e);
        $display("issue %h / %h, expect q=%h r=%h dz=%b be=%b L=%0d", dvd, dvs, q, r, dz, be, lat);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                break;
            end
            if (!bus.busy) busy_low++;
            bus.start = 1'b0;
            if (glitch > 0 && i == glitch) begin
                // ignored: the divider is busy
                bus.start    = 1'b1;
                bus.dividend = 16'h9999;
                bus.divisor  = 16'h0001;
            end
        end
        bus.start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done in 60 cycles, expected done after %0d", lat);
        end
        chk("busy_during_op", 32'(busy_low), 32'd0);
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_quotient",  32'(bus.quotient),  32'h0);
        chk("reset_remainder", 32'(bus.remainder), 32'h0);
        chk("reset_busy",      32'(bus.busy),      32'h0);
        chk("reset_done",      32'(bus.done),      32'h0);
        rst = 1'b0;
        @(negedge clk);

        run(16'h1234, 16'h0005, 16'h0246, 16'h0004, 1'b0, 1'b0, 20, 0);
        run(16'h9999, 16'h0001, 16'h9999, 16'h0000, 1'b0, 1'b0, 44, 0);
        run(16'h0042, 16'h0100, 16'h0000, 16'h0042, 1'b0, 1'b0, 8, 0);
        run(16'h0777, 16'h0000, 16'h9999, 16'h0777, 1'b1, 1'b0, 1, 0);

        // Abort an operation with reset after edge 5
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h1234;
        bus.divisor  = 16'h0005;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        $display("reset asserted mid-operation");
        chk("abort_quotient",  32'(bus.quotient),  32'h0);
        chk("abort_remainder", 32'(bus.remainder), 32'h0);
        chk("abort_div_zero",  32'(bus.div_zero),  32'h0);
        chk("abort_busy",      32'(bus.busy),      32'h0);
        chk("abort_done",      32'(bus.done),      32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run(16'h0100, 16'h0007, 16'h0014, 16'h0002, 1'b0, 1'b0, 13, 3);

`ifdef BCD_DIV_DIGIT_CHECK_EN
        run(16'h12A4, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, 0);
`endif

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pending_results: got %0d unanswered, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
